// File: rtl/jtag_pkg.sv
// Shared JTAG data-path definitions: default word width, receiver state
// encoding and the IDCODE constant used by the benches.
package jtag_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 32;

  // Device identification word returned in Shift-DR after IDCODE is selected.
  localparam logic [31:0] IDCODE = 32'h4BA0_0477;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

endpackage : jtag_pkg

// File: rtl/byte_receiver.sv
// byte_receiver: JTAG serial-to-parallel deserializer.
// Samples TDI MSB first on posedge TCK while enable is high and presents each
// completed WIDTH-bit word on out with a one-cycle valid strobe. Dropping
// enable mid-word discards the partial word.
//
// Ports:
//   clk      TCK, all state updates on posedge
//   reset    synchronous active-low reset
//   enable   high during Shift-DR; low aborts any partial word
//   in       serial TDI bit
//   out      last completed word, held until the next completion
//   valid    one-cycle pulse in the cycle after the WIDTH-th bit is sampled
//   count    bits captured in the current partial word (0..WIDTH-1)
//   ack      (BYTE_RECEIVER_OVERRUN_EN only) consumer has taken out
//   overrun  (BYTE_RECEIVER_OVERRUN_EN only) sticky: a word completed while
//            the previous one was still unacknowledged
//
// Build option: define BYTE_RECEIVER_OVERRUN_EN to add ack/overrun tracking.
module byte_receiver
  import jtag_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WORD_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
`ifdef BYTE_RECEIVER_OVERRUN_EN
  input  logic             ack,
  output logic             overrun,
`endif
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SHW = WIDTH - 1;

  // Elaboration-time legality checks.
  if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
    $error("byte_receiver: WIDTH must be in 2..63");
  end
  if (CNT_W != $clog2(WIDTH + 1)) begin : g_bad_cnt_w
    $error("byte_receiver: CNT_W is derived from WIDTH and must not be overridden");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  rx_state_t        state_q;
  logic [SHW-1:0]   shift_q;   // only WIDTH-1 bits are ever needed before completion
  logic [WIDTH-1:0] out_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             done_c;

  // High on the edge that samples the final bit of a word.
  assign done_c = (state_q == RX_SHIFT) && enable && (count_q == LAST_CNT);

  // Receiver FSM, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      shift_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          count_q <= '0;
          if (enable) begin
            shift_q <= SHW'(in);
            count_q <= CNT_W'(1);
            state_q <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (!enable) begin
            count_q <= '0;
            state_q <= RX_IDLE;
          end else if (count_q == LAST_CNT) begin
            // Next word's first bit lands on the following edge, no gap cycle.
            out_q   <= {shift_q, in};
            valid_q <= 1'b1;
            count_q <= '0;
          end else begin
            shift_q <= SHW'({shift_q, in});
            count_q <= count_q + CNT_W'(1);
          end
        end
        default: begin
          count_q <= '0;
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign count = count_q;

`ifdef BYTE_RECEIVER_OVERRUN_EN
  logic pending_q;
  logic overrun_q;

  // A completion re-arms pending even if ack arrives on the same edge, since
  // that ack refers to the word being replaced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (done_c) begin
        pending_q <= 1'b1;
      end else if (ack) begin
        pending_q <= 1'b0;
      end
      if (done_c && pending_q && !ack) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign overrun = overrun_q;
`endif

endmodule : byte_receiver

// File: tb/tb_byte_receiver.sv
// Directed self-checking bench for byte_receiver (WIDTH = 32).
module tb_byte_receiver;
  import jtag_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk;
  logic          reset;
  logic          enable;
  logic          in;
  logic [W-1:0]  out;
  logic          valid;
  logic [CW-1:0] count;
`ifdef BYTE_RECEIVER_OVERRUN_EN
  logic          ack;
  logic          overrun;
`endif

  byte_receiver #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (in),
`ifdef BYTE_RECEIVER_OVERRUN_EN
    .ack    (ack),
    .overrun(overrun),
`endif
    .out    (out),
    .valid  (valid),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [W-1:0] model_out;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    bit          drop;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift the top nbits of data MSB first, checking every cycle.
  task automatic send_bits(input logic [31:0] data, input int nbits, input string tag);
    for (int k = 1; k <= nbits; k++) begin
      enable = 1'b1;
      in     = data[W-k];
      tick();
      if (k == W) model_out = data;
      chk({tag, " valid"}, 32'(valid), (k == W) ? 32'd1 : 32'd0);
      chk({tag, " count"}, 32'(count), 32'(k % W));
      chk({tag, " out"}, out, model_out);
    end
  endtask

  task automatic idle_check(input string tag);
    enable = 1'b0;
    in     = 1'b0;
    tick();
    chk({tag, " idle valid"}, 32'(valid), 32'd0);
    chk({tag, " idle count"}, 32'(count), 32'd0);
    chk({tag, " idle out"}, out, model_out);
  endtask

  initial begin
    vecs[0] = '{data: 32'hDEAD_BEEF, nbits: 32, drop: 1'b1, exp_out: 32'hDEAD_BEEF};
    vecs[1] = '{data: 32'h1234_5678, nbits: 32, drop: 1'b0, exp_out: 32'h1234_5678};
    vecs[2] = '{data: 32'hCAFE_F00D, nbits: 32, drop: 1'b1, exp_out: 32'hCAFE_F00D};
    vecs[3] = '{data: 32'hFFFF_FFFF, nbits: 17, drop: 1'b1, exp_out: 32'hCAFE_F00D};
    vecs[4] = '{data: 32'h0000_A5A5, nbits: 32, drop: 1'b1, exp_out: 32'h0000_A5A5};
    vecs[5] = '{data: IDCODE,        nbits: 32, drop: 1'b1, exp_out: IDCODE};

    model_out = '0;
    enable    = 1'b1;
    in        = 1'b1;
    reset     = 1'b0;
`ifdef BYTE_RECEIVER_OVERRUN_EN
    ack       = 1'b0;
`endif

    // Reset dominates enable/in.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset out", out, 32'h0);
      chk("reset valid", 32'(valid), 32'd0);
      chk("reset count", 32'(count), 32'd0);
    end
    reset = 1'b1;
    idle_check("post reset");

    // Table: single word, back-to-back pair, abort, recovery, IDCODE.
    for (int v = 0; v < 6; v++) begin
      send_bits(vecs[v].data, vecs[v].nbits, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d final out", v), out, vecs[v].exp_out);
      if (vecs[v].drop) idle_check($sformatf("vec%0d", v));
    end

    // Reset mid-word loses the partial word and clears out.
    send_bits(32'h8000_0001, 10, "midrst pre");
    reset = 1'b0;
    tick();
    model_out = '0;
    chk("midrst out", out, 32'h0);
    chk("midrst count", 32'(count), 32'd0);
    chk("midrst valid", 32'(valid), 32'd0);
    reset = 1'b1;
    send_bits(32'h8000_0001, 32, "midrst word");
    idle_check("midrst");

`ifdef BYTE_RECEIVER_OVERRUN_EN
    // Two words with no ack -> sticky overrun.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_out = '0;
    chk("ovr after reset", 32'(overrun), 32'd0);
    send_bits(32'h1111_2222, 32, "ovr w1");
    chk("ovr w1 overrun", 32'(overrun), 32'd0);
    send_bits(32'h3333_4444, 32, "ovr w2");
    chk("ovr w2 overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle_check("ovr hold");
      chk("ovr sticky", 32'(overrun), 32'd1);
    end

    // Ack held from the first valid cycle: no overrun, including the
    // ack-coincides-with-completion case on word 2.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_out = '0;
    chk("ack reset overrun", 32'(overrun), 32'd0);
    send_bits(32'h5555_6666, 32, "ack w1");
    ack = 1'b1;
    send_bits(32'h7777_8888, 32, "ack w2");
    chk("ack w2 overrun", 32'(overrun), 32'd0);
    // Word 2 re-armed pending despite ack on its completion edge.
    ack = 1'b0;
    send_bits(32'h9999_AAAA, 32, "ack w3");
    chk("ack w3 overrun", 32'(overrun), 32'd1);
    idle_check("ack end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_byte_receiver

// File: doc/byte_receiver.md
Name: byte_receiver

Overview:
- Serial-to-parallel deserializer for the JTAG data path; the receive counterpart of the TDO word transmitter.
- Samples TDI one bit per clock on the rising edge while enable is high, MSB first, and assembles WIDTH-bit words.
- Presents each completed word to the TAP/register logic with a one-cycle valid strobe.
- Sits between the TAP controller (which drives enable during Shift-DR) and the instruction/data register bank.

Parameters:
- WIDTH, 32, bits per word; legal range 2..63.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  TCK; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- enable  input  1  high while shifting (Shift-DR); low aborts any partial word.
- in  input  1  serial TDI bit; sampled on posedge clk when enable=1.
- out  output  WIDTH  last completed word; holds until the next completion.
- valid  output  1  one-cycle pulse in the cycle after the WIDTH-th bit is sampled.
- count  output  CNT_W  bits captured in the current partial word (0..WIDTH-1).

Behaviour:
- Reset (reset=0 at posedge) gives: shift register=0, out=0, valid=0, count=0, state=IDLE. Reset has priority over every other input, including mid-word; the partial word is lost.
- State machine has two states, IDLE and SHIFT.
  - IDLE: count=0. When enable=1, sample in into shift[0], set count=1, go to SHIFT. Stay in IDLE while enable=0.
  - SHIFT with enable=1 and count<WIDTH-1: shift <= {shift[WIDTH-2:0], in}; count <= count+1.
  - SHIFT with enable=1 and count==WIDTH-1: out <= {shift[WIDTH-2:0], in}; valid <= 1; count <= 0; stay in SHIFT.
  - SHIFT with enable=0: discard the partial word; count <= 0; go to IDLE. out is unchanged and valid=0.
- Bit order: the first bit sampled after enable rises lands in out[WIDTH-1]; the last bit lands in out[0].
- Back-to-back words: if enable stays high, bit 0 of the next word is sampled on the posedge immediately after the completing bit. There are no gap cycles.
- valid is 0 on every cycle except the one directly following completion. It is never high for two consecutive cycles, because WIDTH≥2.
- Latency: valid and the new out appear together at the posedge that samples the final bit, so they are visible during the following cycle.
- WIDTH=1 is illegal; an elaboration-time check fails the build.
- The upstream source drives on negedge; the receiver samples on posedge, giving a half-cycle setup margin. No negedge logic is used in this block.

Optional Feature:
- Macro: BYTE_RECEIVER_OVERRUN_EN.
- With the macro defined, the block adds an input ack (1 bit) and an output overrun (1 bit).
  - An internal pending flag sets on valid and clears on ack.
  - If a word completes while pending=1, overrun sets and stays set (sticky) until reset. The new word still overwrites out.
  - If ack and completion occur in the same cycle, pending stays 1 and overrun does not set.
- Without the macro: no ack or overrun ports, no pending flag; out is simply overwritten.

Decomposition:
- A shared package jtag_pkg holds:
  - DEFAULT_WORD_WIDTH = 32;
  - the rx_state_t enum {RX_IDLE, RX_SHIFT};
  - the IDCODE constant used by benches.
- No sub-module: the counter and shift register are inline.
- Optionally reuse a generic shift_reg_sipo only if one already exists in the library.

Test Plan:
- Reset: hold reset=0 for 3 cycles with enable=1 and in=1 -> out=0, valid=0, count=0 throughout.
- Single word: enable=1 for 32 cycles, shifting 0xDEADBEEF MSB first -> valid=1 for exactly one cycle after bit 32, out=0xDEADBEEF, count returns to 0.
- Back-to-back: 64 continuous bits of 0x12345678 then 0xCAFEF00D -> two valid pulses 32 cycles apart, with out=0x12345678 then 0xCAFEF00D.
- Abort: drive 0xFFFFFFFF, drop enable after 17 bits, then send a full 0x0000A5A5 -> no valid after the partial word, out=0xFFFFFFFF is never produced, final out=0x0000A5A5.
- Reset mid-word: reset=0 after 10 bits, then a full 0x80000001 -> single valid, out=0x80000001.
- BYTE_RECEIVER_OVERRUN_EN: two words with no ack -> overrun=1 after the second valid and stays set. The same sequence with ack asserted on the first valid cycle -> overrun=0.
